// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared FSM type, sizing helpers and reset coefficient for fir_filter_mc
package fir_mc_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int acc_w(input int dw, input int cw, input int n);
    return dw + cw + $clog2(n);
  endfunction
  function automatic logic [63:0] rst_coef(input int k, input int shift);
    return (k == 0) ? (64'd1 << shift) : 64'd0;
  endfunction
endpackage

// File: rtl/fir_mc_coef_bank.sv
// fir_mc_coef_bank: shadow/active coefficient banks with deferred commit and tap read mux
module fir_mc_coef_bank import fir_mc_pkg::*; #(
  parameter int NTAPS = 33,
  parameter int COEF_W = 32,
  parameter int OUT_SHIFT = 16,
  localparam int AW = idx_w(NTAPS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic coef_wr,
  input  logic [AW-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic coef_commit,
  input  logic commit_ok,
  input  logic [AW-1:0] rd_addr,
  output logic signed [COEF_W-1:0] rd_data,
  output logic coef_pending
);
  logic signed [COEF_W-1:0] shadow_q [NTAPS];
  logic signed [COEF_W-1:0] active_q [NTAPS];
  logic pending_q, pending_d, copy, wr_ok;
  assign wr_ok = coef_wr && int'(coef_addr) < NTAPS;
  assign copy = pending_q && commit_ok;
  // a commit arriving in the copy cycle re-arms, so a same-cycle write still lands
  assign pending_d = coef_commit || (pending_q && !copy);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= COEF_W'(rst_coef(i, OUT_SHIFT));
        active_q[i] <= COEF_W'(rst_coef(i, OUT_SHIFT));
      end
      pending_q <= 1'b0;
    end else if (enable) begin
      if (wr_ok) shadow_q[coef_addr] <= coef_data;
      if (copy) active_q <= shadow_q;
      pending_q <= pending_d;
    end
  assign rd_data = active_q[rd_addr];
  assign coef_pending = pending_q;
endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed single-MAC FIR with runtime coefficient reload and bypass.
// Define FIR_FILTER_MC_SAT_EN to saturate results and expose sat_flag.
module fir_filter_mc import fir_mc_pkg::*; #(
  parameter int NTAPS = 33,
  parameter int DATA_W = 64,
  parameter int COEF_W = 32,
  parameter int OUT_W = 64,
  parameter int OUT_SHIFT = 16,
  localparam int AW = idx_w(NTAPS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic bypass,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic data_in_valid,
  output logic data_in_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic data_out_valid,
  input  logic coef_wr,
  input  logic [AW-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic coef_commit,
  output logic coef_pending,
  output logic busy
`ifdef FIR_FILTER_MC_SAT_EN
  ,
  output logic sat_flag
`endif
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  state_e state_q;
  logic [AW-1:0] k_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [OUT_W-1:0] out_q, res;
  logic valid_q, accept, commit_ok;
  logic signed [COEF_W-1:0] c_k;
  logic signed [PROD_W-1:0] prod;
  assign data_in_ready = reset_n && enable && state_q == IDLE;
  assign accept = data_in_valid && data_in_ready;
  assign commit_ok = state_q == IDLE && !accept;
  fir_mc_coef_bank #(
    .NTAPS(NTAPS),
    .COEF_W(COEF_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_bank (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .coef_wr(coef_wr),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_commit(coef_commit),
    .commit_ok(commit_ok),
    .rd_addr(k_q),
    .rd_data(c_k),
    .coef_pending(coef_pending)
  );
  assign prod = x_q[k_q] * c_k;
  assign acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`ifdef FIR_FILTER_MC_SAT_EN
  logic signed [ACC_W-1:0] acc_sh;
  logic [ACC_W-OUT_W:0] hi;
  logic res_sat, sat_q;
  assign acc_sh = acc_d >>> OUT_SHIFT;
  assign hi = acc_sh[ACC_W-1:OUT_W-1];
  // representable only when every bit above the output sign bit matches it
  assign res_sat = !(&hi || !(|hi));
  assign res = !res_sat ? acc_sh[OUT_W-1:0] :
               acc_sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  assign sat_flag = sat_q && enable;
`else
  assign res = OUT_W'(acc_d >>> OUT_SHIFT);
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
`ifdef FIR_FILTER_MC_SAT_EN
      sat_q <= 1'b0;
`endif
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (enable) begin
      valid_q <= 1'b0;
`ifdef FIR_FILTER_MC_SAT_EN
      sat_q <= 1'b0;
`endif
      if (accept) begin
        x_q[0] <= data_in;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      end
      case (state_q)
        IDLE:
          if (accept && bypass) begin
            out_q <= OUT_W'(data_in);
            valid_q <= 1'b1;
          end else if (accept) begin
            acc_q <= '0;
            k_q <= '0;
            state_q <= MAC;
          end
        MAC: begin
          acc_q <= acc_d;
          k_q <= k_q + AW'(1);
          if (k_q == LAST) begin
            out_q <= res;
            valid_q <= 1'b1;
`ifdef FIR_FILTER_MC_SAT_EN
            sat_q <= res_sat;
`endif
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign data_out = out_q;
  assign data_out_valid = valid_q && enable;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc: scoreboard bench with a sum-of-products reference model
module tb_fir_filter_mc;
  localparam int NT = 4, DW = 16, CW = 16, OW = 24, SH = 0;
  typedef struct {longint v; bit s;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b1, bypass = 1'b0, din_v = 1'b0, coef_wr = 1'b0, coef_commit = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic [1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic din_rdy, dout_v, pend, busy, sat;
  logic signed [OW-1:0] dout;
  logic s_v = 1'b0, s_wr = 1'b0, s_cm = 1'b0, s_addr = 1'b0;
  logic signed [15:0] s_d = '0, s_cd = '0;
  logic s_rdy, s_dv, s_pend, s_busy, s_sat;
  logic signed [7:0] s_out;
  int checks = 0, errors = 0, mbusy = 0;
  int m_sh [NT], m_act [NT], m_hist [NT];
  bit m_pend = 1'b0, last_valid = 1'b0;
  exp_t exp_q [$];
  exp_t mon_e;
  always #5 clk = ~clk;
  fir_filter_mc #(.NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(SH)) u_dut (
    .clk(clk), .reset_n(rst_n), .enable(en), .bypass(bypass), .data_in(din),
    .data_in_valid(din_v), .data_in_ready(din_rdy), .data_out(dout), .data_out_valid(dout_v),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .coef_pending(pend), .busy(busy)
`ifdef FIR_FILTER_MC_SAT_EN
    , .sat_flag(sat)
`endif
  );
  fir_filter_mc #(.NTAPS(2), .DATA_W(16), .COEF_W(16), .OUT_W(8), .OUT_SHIFT(0)) u_sat (
    .clk(clk), .reset_n(rst_n), .enable(1'b1), .bypass(1'b0), .data_in(s_d),
    .data_in_valid(s_v), .data_in_ready(s_rdy), .data_out(s_out), .data_out_valid(s_dv),
    .coef_wr(s_wr), .coef_addr(s_addr), .coef_data(s_cd), .coef_commit(s_cm),
    .coef_pending(s_pend), .busy(s_busy)
`ifdef FIR_FILTER_MC_SAT_EN
    , .sat_flag(s_sat)
`endif
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t fin(input longint s, input int w);
    longint m = longint'(1) << w;
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -(longint'(1) << (w - 1));
    exp_t r;
`ifdef FIR_FILTER_MC_SAT_EN
    r.s = s > mx || s < mn;
    r.v = s > mx ? mx : (s < mn ? mn : s);
`else
    r.s = 1'b0;
    r.v = s & (m - 1);
    if (r.v > mx) r.v -= m;
`endif
    return r;
  endfunction
  function automatic int rs16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_sh[k] = (k == 0) ? (1 << SH) : 0;
      m_act[k] = m_sh[k];
      m_hist[k] = 0;
    end
    m_pend = 1'b0;
    mbusy = 0;
    exp_q.delete();
  endtask
  task automatic cyc(input bit v, input int d, input bit b, input bit e,
                     input bit w, input int a, input int cd, input bit cm);
    bit acc, cp;
    longint s;
    @(negedge clk);
    din_v = v; din = DW'(d); bypass = b; en = e;
    coef_wr = w; coef_addr = 2'(a); coef_data = CW'(cd); coef_commit = cm;
    #1;
    last_valid = dout_v;
    chk("data_in_ready", din_rdy, e && mbusy == 0);
    chk("busy", busy, mbusy != 0);
    chk("coef_pending", pend, m_pend);
    acc = v && e && mbusy == 0;
    @(posedge clk);
    if (e) begin
      cp = m_pend && mbusy == 0 && !acc;
      if (cp) m_act = m_sh;
      if (w) m_sh[a] = cd;
      m_pend = cm || (m_pend && !cp);
      if (mbusy > 0) mbusy--;
      if (acc) begin
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        if (b) exp_q.push_back('{longint'(d), 1'b0});
        else begin
          s = 0;
          for (int k = 0; k < NT; k++) s += longint'(m_hist[k]) * longint'(m_act[k]);
          exp_q.push_back(fin(s >>> SH, OW));
          mbusy = NT + 1;
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic feed(input int d, input bit b);
    cyc(1, d, b, 1, 0, 0, 0, 0);
  endtask
  task automatic wr(input int a, input int cd, input bit cm);
    cyc(0, 0, 0, 1, 1, a, cd, cm);
  endtask
  task automatic wait_lat(input string nm, input int exp);
    int n = 0;
    do begin
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      n++;
    end while (!last_valid && n < 40);
    chk(nm, n, exp);
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "_data_out"}, dout, 0);
    chk({nm, "_valid"}, dout_v, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pending"}, pend, 0);
    chk({nm, "_ready"}, din_rdy, 0);
  endtask
  task automatic s_cyc(input bit v, input int d, input bit w, input int a, input int cd, input bit cm);
    @(negedge clk);
    s_v = v; s_d = 16'(d); s_wr = w; s_addr = 1'(a); s_cd = 16'(cd); s_cm = cm;
  endtask
  task automatic s_wait(input string nm, input longint ev, input bit es);
    int n = 0;
    do begin
      s_cyc(0, 0, 0, 0, 0, 0);
      #1;
      n++;
    end while (!s_dv && n < 20);
    chk({nm, "_lat"}, n, 3);
    chk(nm, s_out, ev);
`ifdef FIR_FILTER_MC_SAT_EN
    chk({nm, "_sat_flag"}, s_sat, es);
`else
    if (es && s_dv) chk({nm, "_wrapped"}, s_out, ev);
`endif
  endtask
  always @(negedge clk) begin
    #2;
    if (rst_n && dout_v) begin
      if (exp_q.size() == 0) chk("spurious_data_out_valid", dout_v, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("data_out", dout, mon_e.v);
`ifdef FIR_FILTER_MC_SAT_EN
        chk("sat_flag", sat, mon_e.s);
`endif
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
  initial begin
    exp_t e;
    int n;
    #1 rst_n = 1'b0;
    #2 chk_rst("reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    feed(5, 0);  wait_lat("lat_ident_a", NT + 1);
    feed(-3, 0); wait_lat("lat_ident_b", NT + 1);
    feed(7, 0);  wait_lat("lat_ident_c", NT + 1);
    wr(0, 2, 0);
    cyc(1, 10, 0, 1, 0, 0, 0, 1);
    wait_lat("lat_commit_accept", NT + 1);
    idle(1);
    feed(6, 0); wait_lat("lat_new_bank", NT + 1);
    wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 0); wr(3, 4, 1);
    idle(1);
    for (int i = 0; i < 3; i++) feed(0, 1);
    idle(1);
    feed(1, 0); wait_lat("lat_imp0", NT + 1);
    for (int i = 0; i < 3; i++) begin
      feed(0, 0);
      wait_lat("lat_imp", NT + 1);
    end
    feed(100, 1);
    feed(200, 1);
    chk("bypass_latency", last_valid, 1);
    feed(300, 1);
    idle(2);
    feed(9, 0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    wait_lat("lat_enable_hold", 3);
    feed(42, 0);
    idle(2);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_rst("midop_reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    feed(-8, 0); wait_lat("lat_after_reset", NT + 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, rs16(), $urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 4) == 0, int'($urandom_range(0, NT - 1)), rs16(), $urandom_range(0, 19) == 0);
    n = 0;
    while ((mbusy != 0 || exp_q.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    s_cyc(0, 0, 1, 0, 100, 0);
    s_cyc(0, 0, 1, 1, 100, 1);
    s_cyc(0, 0, 0, 0, 0, 0);
    s_cyc(1, 2, 0, 0, 0, 0);
    e = fin(200, 8);
    s_wait("sat_out_200", e.v, e.s);
    s_cyc(1, 2, 0, 0, 0, 0);
    e = fin(400, 8);
    s_wait("sat_out_400", e.v, e.s);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
